// File: rtl/pool_seq_ctrl.sv
// Sequencer feeding a registered max-pool datapath: streams PE elements as CNN_FIN beats,
// closes each window with POOL_FIN and captures the window max, then reports job completion.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module pool_seq_ctrl #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int WIN_W    = 4,
  parameter int NWIN_W   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIN_W-1:0]           cfg_win,
  input  logic [NWIN_W-1:0]          cfg_nwin,
  input  logic                       pe_valid,
  input  logic signed [DATA_WID-1:0] pe_data,
  output logic                       pe_ready,
  output logic [2:0]                 pool_state,
  output logic [DATA_WID-1:0]        pool_data,
  input  logic [DATA_WID-1:0]        pool_res_data,
  output logic                       res_valid,
  output logic [DATA_WID-1:0]        res_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] PS_INVALID  = 3'd0;
  localparam logic [2:0] PS_CNN_FIN  = 3'd2;
  localparam logic [2:0] PS_POOL_FIN = 3'd3;
  localparam logic [2:0] PS_COMPL    = 3'd4;

  state_t              state, state_nxt;
  logic [WIN_W-1:0]    elem_cnt, elem_nxt;
  logic [NWIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [WIN_W-1:0]    win_cfg, win_cfg_nxt;
  logic [NWIN_W-1:0]   nwin_cfg, nwin_cfg_nxt;
  logic [2:0]          ps_nxt;
  logic [DATA_WID-1:0] pd_nxt, rd_nxt;
  logic                rv_nxt, done_nxt, err_nxt;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    elem_nxt     = elem_cnt;
    win_cnt_nxt  = win_cnt;
    win_cfg_nxt  = win_cfg;
    nwin_cfg_nxt = nwin_cfg;
    ps_nxt       = PS_INVALID;
    pd_nxt       = '0;
    rd_nxt       = res_data;
    rv_nxt       = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    pe_ready     = 1'b0;

    // Abort wins over every in-job transition; POOL_FIN tells the datapath to drop its partial max.
    if (state != S_IDLE && abort) begin
      state_nxt   = S_IDLE;
      ps_nxt      = PS_POOL_FIN;
      elem_nxt    = '0;
      win_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_win != '0 && cfg_nwin != '0) begin
              win_cfg_nxt  = cfg_win;
              nwin_cfg_nxt = cfg_nwin;
              elem_nxt     = '0;
              win_cnt_nxt  = '0;
              state_nxt    = S_ACCUM;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        S_ACCUM: begin
          pe_ready = 1'b1;
          if (pe_valid) begin
            ps_nxt = PS_CNN_FIN;
            pd_nxt = pe_data;
            if (elem_cnt == win_cfg - WIN_W'(1)) begin
              elem_nxt  = '0;
              state_nxt = S_DRAIN;
            end else begin
              elem_nxt = elem_cnt + WIN_W'(1);
            end
          end
        end
        // One idle cycle lets the datapath register the window's last element.
        S_DRAIN: state_nxt = S_FLUSH;
        S_FLUSH: begin
          ps_nxt      = PS_POOL_FIN;
          rd_nxt      = pool_res_data;
          rv_nxt      = 1'b1;
          win_cnt_nxt = win_cnt + NWIN_W'(1);
          state_nxt   = (win_cnt == nwin_cfg - NWIN_W'(1)) ? S_DONE : S_ACCUM;
        end
        S_DONE: begin
          ps_nxt    = PS_COMPL;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      elem_cnt   <= '0;
      win_cnt    <= '0;
      win_cfg    <= '0;
      nwin_cfg   <= '0;
      pool_state <= PS_INVALID;
      pool_data  <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      elem_cnt   <= elem_nxt;
      win_cnt    <= win_cnt_nxt;
      win_cfg    <= win_cfg_nxt;
      nwin_cfg   <= nwin_cfg_nxt;
      pool_state <= ps_nxt;
      pool_data  <= pd_nxt;
      res_data   <= rd_nxt;
      res_valid  <= rv_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl; a small registered running-max model stands in for the
// max-pool datapath so that captured window results can be checked.
module tb_pool_seq_ctrl;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 reset, start, abort, pe_valid;
  logic [3:0]           cfg_win;
  logic [9:0]           cfg_nwin;
  logic signed [DW-1:0] pe_data;
  logic signed [DW-1:0] pool_res_data = '0;
  logic                 pe_ready, res_valid, busy, done, err;
  logic [2:0]           pool_state;
  logic signed [DW-1:0] pool_data, res_data;

  pool_seq_ctrl #(.DATA_WID(DW), .WIN_W(4), .NWIN_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_win(cfg_win), .cfg_nwin(cfg_nwin), .pe_valid(pe_valid), .pe_data(pe_data),
    .pe_ready(pe_ready), .pool_state(pool_state), .pool_data(pool_data),
    .pool_res_data(pool_res_data), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Running-max datapath model: restarts after POOL_FIN/COMPL or reset.
  logic fresh = 1'b1;
  always @(posedge clk) begin
    if (reset || pool_state == 3'd3 || pool_state == 3'd4) fresh <= 1'b1;
    else if (pool_state == 3'd2) begin
      pool_res_data <= (fresh || pool_data > pool_res_data) ? pool_data : pool_res_data;
      fresh <= 1'b0;
    end
  end

  int checks = 0;
  int passed = 0;
  logic signed [DW-1:0] stream[$];
  int idx = 0;

  task automatic tick();
    logic acc;
    acc = pe_valid && pe_ready;
    @(posedge clk);
    #1;
    if (acc) idx++;
  endtask

  task automatic feed(input logic v);
    pe_valid = v && (idx < stream.size());
    pe_data  = (idx < stream.size()) ? stream[idx] : '0;
  endtask

  task automatic launch(input int w, input int n);
    idx = 0;
    pe_valid = 1'b0;
    start = 1'b1; cfg_win = 4'(w); cfg_nwin = 10'(n);
    tick();
    start = 1'b0; cfg_win = 4'hF; cfg_nwin = 10'd7;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; pe_valid = 1'b0; pe_data = '0;
    cfg_win = '0; cfg_nwin = '0;
    tick(); tick();
    checks++; if (pool_state !== 3'd0) $display("FAIL reset_pool_state: got %0d expected 0", pool_state); else passed++;
    checks++; if (pool_data !== 8'sd0) $display("FAIL reset_pool_data: got %0d expected 0", pool_data); else passed++;
    checks++; if (res_data !== 8'sd0) $display("FAIL reset_res_data: got %0d expected 0", res_data); else passed++;
    checks++; if ({res_valid, done, err, busy, pe_ready} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {res_valid, done, err, busy, pe_ready}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int ps_exp[$];
    int k;
    logic ready_exp;
    ps_exp = '{0,2,2,2,2,0,3,2,2,2,2,0,3,4,0};
    stream = '{-8'sd3, 8'sd7, 8'sd2, 8'sd5, 8'sd1, -8'sd8, 8'sd0, -8'sd2};
    k = 0;
    launch(4, 2);
    for (int c = 1; c <= 15; c++) begin
      checks++; if (pool_state !== 3'(ps_exp[c-1])) $display("FAIL basic_state c%0d: got %0d expected %0d", c, pool_state, ps_exp[c-1]); else passed++;
      if (ps_exp[c-1] == 2) begin
        checks++; if (pool_data !== stream[k]) $display("FAIL basic_data c%0d: got %0d expected %0d", c, pool_data, stream[k]); else passed++;
        k++;
      end
      checks++; if (res_valid !== (c == 7 || c == 13)) $display("FAIL basic_res_valid c%0d: got %0d", c, res_valid); else passed++;
      if (c == 7 || c == 13) begin
        checks++; if (res_data !== ((c == 7) ? 8'sd7 : 8'sd1)) $display("FAIL basic_res_data c%0d: got %0d expected %0d", c, res_data, (c == 7) ? 7 : 1); else passed++;
      end
      checks++; if (done !== (c == 14)) $display("FAIL basic_done c%0d: got %0d", c, done); else passed++;
      checks++; if (busy !== (c <= 13)) $display("FAIL basic_busy c%0d: got %0d", c, busy); else passed++;
      ready_exp = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      checks++; if (pe_ready !== ready_exp) $display("FAIL basic_ready c%0d: got %0d expected %0d", c, pe_ready, ready_exp); else passed++;
      feed(1'b1);
      tick();
    end
  endtask

  task automatic test_gaps();
    int ps_exp[$];
    int k;
    ps_exp = '{0,2,0,2,0,2,0,3,4,0};
    stream = '{-8'sd5, 8'sd9, 8'sd4};
    k = 0;
    launch(3, 1);
    for (int c = 1; c <= 10; c++) begin
      checks++; if (pool_state !== 3'(ps_exp[c-1])) $display("FAIL gaps_state c%0d: got %0d expected %0d", c, pool_state, ps_exp[c-1]); else passed++;
      if (ps_exp[c-1] == 2) begin
        checks++; if (pool_data !== stream[k]) $display("FAIL gaps_data c%0d: got %0d expected %0d", c, pool_data, stream[k]); else passed++;
        k++;
      end
      checks++; if (pe_ready !== (c <= 5)) $display("FAIL gaps_ready c%0d: got %0d", c, pe_ready); else passed++;
      checks++; if (res_valid !== (c == 8)) $display("FAIL gaps_res_valid c%0d: got %0d", c, res_valid); else passed++;
      if (c == 8) begin
        checks++; if (res_data !== 8'sd9) $display("FAIL gaps_res_data: got %0d expected 9", res_data); else passed++;
      end
      checks++; if (done !== (c == 9)) $display("FAIL gaps_done c%0d: got %0d", c, done); else passed++;
      feed(c % 2 == 1);
      tick();
    end
  endtask

  task automatic test_bad_cfg();
    for (int t = 0; t < 2; t++) begin
      start = 1'b1;
      cfg_win  = (t == 0) ? 4'd0 : 4'd3;
      cfg_nwin = (t == 0) ? 10'd2 : 10'd0;
      tick();
      start = 1'b0;
      checks++; if (err !== 1'b1) $display("FAIL badcfg_err t%0d: got %0d expected 1", t, err); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL badcfg_busy t%0d: got %0d expected 0", t, busy); else passed++;
      checks++; if (pool_state !== 3'd0) $display("FAIL badcfg_state t%0d: got %0d expected 0", t, pool_state); else passed++;
      tick();
      checks++; if ({err, busy} !== 2'b00) $display("FAIL badcfg_after t%0d: got %b expected 00", t, {err, busy}); else passed++;
    end
  endtask

  task automatic test_abort();
    int ps_exp[$];
    stream = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    launch(4, 2);
    feed(1'b1); tick();
    feed(1'b1); tick();
    checks++; if (pool_state !== 3'd2 || pool_data !== 8'sd2) $display("FAIL abort_pre: got state %0d data %0d expected 2/2", pool_state, pool_data); else passed++;
    abort = 1'b1;
    #1;
    checks++; if (pe_ready !== 1'b0) $display("FAIL abort_ready: got %0d expected 0", pe_ready); else passed++;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0d expected 0", busy); else passed++;
    checks++; if (pool_state !== 3'd3 || pool_data !== 8'sd0) $display("FAIL abort_poolfin: got state %0d data %0d expected 3/0", pool_state, pool_data); else passed++;
    checks++; if ({res_valid, done} !== 2'b00) $display("FAIL abort_pulses: got %b expected 00", {res_valid, done}); else passed++;
    pe_valid = 1'b0;
    tick();
    checks++; if (pool_state !== 3'd0 || {res_valid, done, busy} !== 3'b000) $display("FAIL abort_after: got state %0d flags %b expected 0/000", pool_state, {res_valid, done, busy}); else passed++;
    ps_exp = '{0,2,2,0,3,4,0};
    stream = '{8'sd4, 8'sd6};
    launch(2, 1);
    for (int c = 1; c <= 7; c++) begin
      checks++; if (pool_state !== 3'(ps_exp[c-1])) $display("FAIL rerun_state c%0d: got %0d expected %0d", c, pool_state, ps_exp[c-1]); else passed++;
      checks++; if (res_valid !== (c == 5)) $display("FAIL rerun_res_valid c%0d: got %0d", c, res_valid); else passed++;
      if (c == 5) begin
        checks++; if (res_data !== 8'sd6) $display("FAIL rerun_res_data: got %0d expected 6", res_data); else passed++;
      end
      checks++; if (done !== (c == 6)) $display("FAIL rerun_done c%0d: got %0d", c, done); else passed++;
      feed(1'b1);
      tick();
    end
  endtask

  task automatic test_win1();
    int ps_exp[$];
    int res_exp[$];
    int k, r;
    ps_exp  = '{0,2,0,3,2,0,3,2,0,3,4,0};
    res_exp = '{-128, 0, 127};
    stream  = '{-8'sd128, 8'sd0, 8'sd127};
    k = 0; r = 0;
    launch(1, 3);
    for (int c = 1; c <= 12; c++) begin
      checks++; if (pool_state !== 3'(ps_exp[c-1])) $display("FAIL win1_state c%0d: got %0d expected %0d", c, pool_state, ps_exp[c-1]); else passed++;
      if (ps_exp[c-1] == 2) begin
        checks++; if (pool_data !== stream[k]) $display("FAIL win1_data c%0d: got %0d expected %0d", c, pool_data, stream[k]); else passed++;
        k++;
      end
      checks++; if (res_valid !== (c == 4 || c == 7 || c == 10)) $display("FAIL win1_res_valid c%0d: got %0d", c, res_valid); else passed++;
      if (c == 4 || c == 7 || c == 10) begin
        checks++; if (res_data !== 8'(res_exp[r])) $display("FAIL win1_res_data c%0d: got %0d expected %0d", c, res_data, res_exp[r]); else passed++;
        r++;
      end
      checks++; if (done !== (c == 11)) $display("FAIL win1_done c%0d: got %0d", c, done); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL win1_err c%0d: got %0d expected 0", c, err); else passed++;
      checks++; if (busy !== (c <= 10)) $display("FAIL win1_busy c%0d: got %0d", c, busy); else passed++;
      start = (c == 3 || c == 6);
      cfg_win = 4'd0; cfg_nwin = 10'd0;
      feed(1'b1);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_flush();
    stream = '{8'sd3, 8'sd5};
    launch(2, 1);
    for (int c = 1; c <= 3; c++) begin
      feed(1'b1);
      tick();
    end
    checks++; if (pool_state !== 3'd0 || busy !== 1'b1) $display("FAIL rflush_pre: got state %0d busy %0d expected 0/1", pool_state, busy); else passed++;
    pe_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (pool_state !== 3'd0 || pool_data !== 8'sd0) $display("FAIL rflush_pool: got state %0d data %0d expected 0/0", pool_state, pool_data); else passed++;
    checks++; if (res_data !== 8'sd0) $display("FAIL rflush_res_data: got %0d expected 0", res_data); else passed++;
    checks++; if ({res_valid, done, err, busy, pe_ready} !== 5'b0) $display("FAIL rflush_flags: got %b expected 00000", {res_valid, done, err, busy, pe_ready}); else passed++;
    reset = 1'b0;
    tick();
    checks++; if ({res_valid, done, busy} !== 3'b000 || pool_state !== 3'd0) $display("FAIL rflush_after: got flags %b state %0d expected 000/0", {res_valid, done, busy}, pool_state); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_gaps();
    tick();
    test_bad_cfg();
    test_abort();
    tick();
    test_win1();
    tick();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
